// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PCSrc encodings, exception vectors
// and the sequential PC increment helper.
package cpu_pkg;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;
    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_EXC = 3'b101;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Bit 31 is the kernel flag; increment never carries into it.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority selector for the fetch stage.
// Also reports whether an ID-stage redirect was accepted.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic [3:0]  pc_region,
    input  logic        ifid_valid,
    input  logic [2:0]  pc_src,
    input  logic [25:0] jt,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] pc_next,
    output logic        id_redirect
);

    always_comb begin
        pc_next     = pc_inc(pc);
        id_redirect = 1'b0;
        if (branch_taken) begin
            pc_next = branch_target;
        end else if (stall) begin
            pc_next = pc;
        end else if (ifid_valid) begin
            case (pc_src)
                PCSRC_J: begin
                    pc_next     = {pc_region, jt, 2'b00};
                    id_redirect = 1'b1;
                end
                PCSRC_JR: begin
                    pc_next     = jr_target;
                    id_redirect = 1'b1;
                end
                PCSRC_IRQ: begin
                    pc_next     = IRQ_VEC;
                    id_redirect = 1'b1;
                end
                PCSRC_EXC: begin
                    pc_next     = EXC_VEC;
                    id_redirect = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, imem address and the
// IF/ID pipeline register with branch/redirect flushing.
module pc_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  pc_src,
    input  logic [25:0] jt,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        flush_idex,
    output logic        kernel_mode
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        id_redirect;

    pc_next_mux #(
        .IRQ_VEC(IRQ_VEC),
        .EXC_VEC(EXC_VEC)
    ) u_mux (
        .pc           (pc),
        .pc_region    (ifid_pc_plus4[31:28]),
        .ifid_valid   (ifid_valid),
        .pc_src       (pc_src),
        .jt           (jt),
        .jr_target    (jr_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .pc_next      (pc_next),
        .id_redirect  (id_redirect)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VEC;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
        end else begin
            pc <= pc_next;
            if (branch_taken) begin
                ifid_instr    <= NOP_INSTR;
                ifid_pc_plus4 <= branch_target + 32'd4;
                ifid_valid    <= 1'b0;
            end else if (stall) begin
                ifid_instr    <= ifid_instr;
                ifid_pc_plus4 <= ifid_pc_plus4;
                ifid_valid    <= ifid_valid;
            end else if (id_redirect) begin
                // Squash the wrong-path word fetched behind the redirect.
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else begin
                ifid_instr    <= imem_data;
                ifid_pc_plus4 <= pc_inc(pc);
                ifid_valid    <= 1'b1;
            end
        end
    end

    assign imem_addr   = pc;
    assign flush_idex  = branch_taken;
    assign kernel_mode = ifid_pc_plus4[31];

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed cycle-by-cycle vector bench for pc_fetch_stage.
// Each row is the input of one cycle and the state after its edge.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pc_src;
    logic [25:0] jt;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        flush_idex;
    logic        kernel_mode;

    int n_checks = 0;
    int n_fails  = 0;

    pc_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .pc_src       (pc_src),
        .jt           (jt),
        .jr_target    (jr_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_valid   (ifid_valid),
        .flush_idex   (flush_idex),
        .kernel_mode  (kernel_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  src;
        logic [25:0] jt;
        logic [31:0] jr;
        logic        br;
        logic [31:0] bt;
        logic        stl;
        logic [31:0] imem;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic row(
        input logic rst, input logic [2:0] src,
        input logic [25:0] j, input logic [31:0] jr,
        input logic br, input logic [31:0] bt,
        input logic stl, input logic [31:0] imem,
        input logic [31:0] e_pc, input logic [31:0] e_instr,
        input logic [31:0] e_pc4, input logic e_valid);
        vec_t v;
        v.rst = rst; v.src = src; v.jt = j; v.jr = jr;
        v.br = br; v.bt = bt; v.stl = stl; v.imem = imem;
        v.e_pc = e_pc; v.e_instr = e_instr;
        v.e_pc4 = e_pc4; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s step %0d: got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        pc_src        = v.src;
        jt            = v.jt;
        jr_target     = v.jr;
        branch_taken  = v.br;
        branch_target = v.bt;
        stall         = v.stl;
        imem_data     = v.imem;
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        check("flush_idex", idx, {31'b0, flush_idex}, {31'b0, v.br});
        @(posedge clk);
        #1;
        check("imem_addr", idx, imem_addr, v.e_pc);
        check("ifid_instr", idx, ifid_instr, v.e_instr);
        check("ifid_pc_plus4", idx, ifid_pc_plus4, v.e_pc4);
        check("ifid_valid", idx, {31'b0, ifid_valid}, {31'b0, v.e_valid});
        check("kernel_mode", idx, {31'b0, kernel_mode},
              {31'b0, v.e_pc4[31]});
    endtask

    initial begin
        vec_t h;
        // rst src jt jr br bt stl imem | pc instr pc4 valid
        row(1, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h2408_0005,
            32'h8000_0000, 32'h0, 32'h0, 0);
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h2408_0005,
            32'h8000_0004, 32'h2408_0005, 32'h8000_0004, 1);
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h2408_0005,
            32'h8000_0008, 32'h2408_0005, 32'h8000_0008, 1);
        row(0, 3'd3, 26'h0, 32'h0000_0010, 0, 32'h0, 0, 32'hdead_beef,
            32'h0000_0010, 32'h0, 32'h8000_0008, 0);
        // pc_src ignored while IF/ID is a bubble
        row(0, 3'd3, 26'h0, 32'h0000_0010, 0, 32'h0, 0, 32'h0800_0040,
            32'h0000_0014, 32'h0800_0040, 32'h0000_0014, 1);
        row(0, 3'd2, 26'h40, 32'h0, 0, 32'h0, 0, 32'hdead_beef,
            32'h0000_0100, 32'h0, 32'h0000_0014, 0);
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h1111_1111,
            32'h0000_0104, 32'h1111_1111, 32'h0000_0104, 1);
        // branch beats stall and jump
        row(0, 3'd2, 26'h3ff, 32'h0, 1, 32'h0000_0200, 1, 32'hdead_beef,
            32'h0000_0200, 32'h0, 32'h0000_0204, 0);
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h2222_2222,
            32'h0000_0204, 32'h2222_2222, 32'h0000_0204, 1);
        row(0, 3'd3, 26'h0, 32'h0000_0300, 0, 32'h0, 1, 32'hdead_beef,
            32'h0000_0204, 32'h2222_2222, 32'h0000_0204, 1);
        row(0, 3'd3, 26'h0, 32'h0000_0300, 0, 32'h0, 1, 32'hdead_beef,
            32'h0000_0204, 32'h2222_2222, 32'h0000_0204, 1);
        row(0, 3'd3, 26'h0, 32'h0000_0300, 0, 32'h0, 0, 32'hdead_beef,
            32'h0000_0300, 32'h0, 32'h0000_0204, 0);
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h3333_3333,
            32'h0000_0304, 32'h3333_3333, 32'h0000_0304, 1);
        row(0, 3'd4, 26'h0, 32'h0, 0, 32'h0, 0, 32'hdead_beef,
            32'h8000_0004, 32'h0, 32'h0000_0304, 0);
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h4444_4444,
            32'h8000_0008, 32'h4444_4444, 32'h8000_0008, 1);
        row(0, 3'd5, 26'h0, 32'h0, 0, 32'h0, 0, 32'hdead_beef,
            32'h8000_0008, 32'h0, 32'h8000_0008, 0);
        row(0, 3'd5, 26'h0, 32'h0, 0, 32'h0, 0, 32'h5555_5555,
            32'h8000_000c, 32'h5555_5555, 32'h8000_000c, 1);
        row(0, 3'd3, 26'h0, 32'h7fff_fffc, 0, 32'h0, 0, 32'hdead_beef,
            32'h7fff_fffc, 32'h0, 32'h8000_000c, 0);
        // increment wraps bits 30:0, bit 31 stays clear
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h6666_6666,
            32'h0000_0000, 32'h6666_6666, 32'h0000_0000, 1);
        row(0, 3'd1, 26'h0, 32'h0, 0, 32'h0, 0, 32'h8888_8888,
            32'h0000_0004, 32'h8888_8888, 32'h0000_0004, 1);
        row(0, 3'd3, 26'h0, 32'h0000_0500, 0, 32'h0, 1, 32'hdead_beef,
            32'h0000_0004, 32'h8888_8888, 32'h0000_0004, 1);
        // reset during stall and branch
        row(1, 3'd3, 26'h0, 32'h0000_0500, 1, 32'h0000_0900, 1, 32'hdead_beef,
            32'h8000_0000, 32'h0, 32'h0, 0);
        row(0, 3'd0, 26'h0, 32'h0, 0, 32'h0, 0, 32'h7777_7777,
            32'h8000_0004, 32'h7777_7777, 32'h8000_0004, 1);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], i);

        // Jump keeps the region bits of the kernel-space IF/ID PC+4.
        h = vecs[vecs.size() - 1];
        h.src = 3'd2; h.jt = 26'h10; h.imem = 32'hdead_beef;
        drive(h);
        @(posedge clk);
        #1;
        check("j_kernel_addr", 100, imem_addr, 32'h8000_0040);
        check("j_kernel_valid", 100, {31'b0, ifid_valid}, 32'h0);
        @(negedge clk);
        h.src = 3'd0; h.imem = 32'h9999_9999;
        drive(h);
        @(posedge clk);
        #1;
        check("j_kernel_instr", 101, ifid_instr, 32'h9999_9999);
        check("j_kernel_pc4", 101, ifid_pc_plus4, 32'h8000_0044);
        check("j_kernel_mode", 101, {31'b0, kernel_mode}, 32'h1);

        // Unused code 110 behaves sequentially.
        @(negedge clk);
        h.src = 3'd6; h.imem = 32'haaaa_aaaa;
        drive(h);
        @(posedge clk);
        #1;
        check("src6_addr", 102, imem_addr, 32'h8000_0048);
        check("src6_instr", 102, ifid_instr, 32'haaaa_aaaa);
        check("src6_valid", 102, {31'b0, ifid_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
